// File: rtl/ifu_dispatch_queue.sv
// In-order dispatch queue: accepts a 0-4 lane prefix from the IFU and issues up to two oldest entries.
// Optional perf counters are enabled with `define MERCURY_DISPATCH_PERF_EN.
module ifu_dispatch_queue #(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             ifu_instA_valid,
  output logic             ifu_instA_allowIn,
  input  logic [31:0]      ifu_instA_data,
  input  logic             ifu_instB_valid,
  output logic             ifu_instB_allowIn,
  input  logic [31:0]      ifu_instB_data,
  input  logic             ifu_instC_valid,
  output logic             ifu_instC_allowIn,
  input  logic [31:0]      ifu_instC_data,
  input  logic             ifu_instD_valid,
  output logic             ifu_instD_allowIn,
  input  logic [31:0]      ifu_instD_data,
  output logic             iss0_valid,
  input  logic             iss0_ready,
  output logic [31:0]      iss0_data,
  output logic [SEQ_W-1:0] iss0_seq,
  output logic             iss1_valid,
  input  logic             iss1_ready,
  output logic [31:0]      iss1_data,
  output logic [SEQ_W-1:0] iss1_seq,
`ifdef MERCURY_DISPATCH_PERF_EN
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_full_stall,
  output logic [31:0]      perf_dual_issue,
`endif
  output logic [$clog2(DEPTH):0] q_count,
  output logic             q_full,
  output logic             q_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]    count;
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [SEQ_W-1:0] nextSeq;
  logic [31:0]      memData [DEPTH];
  logic [SEQ_W-1:0] memSeq  [DEPTH];

  logic [3:0]       laneValid;
  logic [31:0]      laneData [4];
  logic [3:0]       allowIn;
  logic [CW-1:0]    free;
  logic [2:0]       pushCnt;
  logic [1:0]       popCnt;
  logic             olderValid;
  logic             fire0;
  logic             fire1;

  assign laneValid = {ifu_instD_valid, ifu_instC_valid, ifu_instB_valid, ifu_instA_valid};
  assign laneData[0] = ifu_instA_data;
  assign laneData[1] = ifu_instB_data;
  assign laneData[2] = ifu_instC_data;
  assign laneData[3] = ifu_instD_data;

  // Free space comes from the registered count only; same-cycle pops never make room.
  assign free = CW'(DEPTH) - count;

  always_comb begin
    allowIn    = '0;
    pushCnt    = '0;
    olderValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      allowIn[k] = rst && !flush && (free >= CW'(k + 1)) && olderValid;
      olderValid = olderValid && laneValid[k];
      if (allowIn[k] && laneValid[k]) pushCnt = pushCnt + 3'd1;
    end
  end

  assign ifu_instA_allowIn = allowIn[0];
  assign ifu_instB_allowIn = allowIn[1];
  assign ifu_instC_allowIn = allowIn[2];
  assign ifu_instD_allowIn = allowIn[3];

  assign iss0_valid = (count >= CW'(1)) && !flush;
  assign iss1_valid = (count >= CW'(2)) && !flush;
  assign iss0_data  = memData[rdPtr];
  assign iss0_seq   = memSeq[rdPtr];
  assign iss1_data  = memData[rdPtr + PW'(1)];
  assign iss1_seq   = memSeq[rdPtr + PW'(1)];

  // Port 1 may only fire alongside port 0 to keep issue strictly in order.
  assign fire0  = iss0_valid && iss0_ready;
  assign fire1  = fire0 && iss1_valid && iss1_ready;
  assign popCnt = 2'(fire0) + 2'(fire1);

  assign q_count = count;
  assign q_full  = (count == CW'(DEPTH));
  assign q_empty = (count == '0);

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (allowIn[k] && laneValid[k]) begin
        memData[wrPtr + PW'(k)] <= laneData[k];
        memSeq[wrPtr + PW'(k)]  <= nextSeq + SEQ_W'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      wrPtr   <= '0;
      rdPtr   <= '0;
      nextSeq <= '0;
    end else if (flush) begin
      count <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      count   <= count + CW'(pushCnt) - CW'(popCnt);
      wrPtr   <= wrPtr + PW'(pushCnt);
      rdPtr   <= rdPtr + PW'(popCnt);
      nextSeq <= nextSeq + SEQ_W'(pushCnt);
    end
  end

`ifdef MERCURY_DISPATCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issued     <= '0;
      perf_full_stall <= '0;
      perf_dual_issue <= '0;
    end else begin
      perf_issued <= perf_issued + 32'(popCnt);
      if (ifu_instA_valid && !allowIn[0] && !flush) perf_full_stall <= perf_full_stall + 32'd1;
      if (popCnt == 2'd2) perf_dual_issue <= perf_dual_issue + 32'd1;
    end
  end
`endif

endmodule
